// File: rtl/mode7_coord_gen_if.sv
// Line-parameter and texel-address bundle between the mode7 line sequencer
// and the coordinate generator; slave is the generator side.
interface mode7_coord_gen_if #(
    parameter int INT_BITS  = 12,
    parameter int FRAC_BITS = 8
);
    logic                          line_start;
    logic [INT_BITS+FRAC_BITS-1:0] line_u0;
    logic [INT_BITS+FRAC_BITS-1:0] line_v0;
    logic [15:0]                   du_dx;
    logic [15:0]                   dv_dx;
    logic                          out_ready;
    logic                          out_valid;
    logic                          out_last;
    logic [3:0]                    texture_idx;
    logic [4:0]                    y_idx;
    logic [4:0]                    x_idx;
    logic                          busy;

    modport master (
        output line_start, line_u0, line_v0, du_dx, dv_dx, out_ready,
        input  out_valid, out_last, texture_idx, y_idx, x_idx, busy
    );

    modport slave (
        input  line_start, line_u0, line_v0, du_dx, dv_dx, out_ready,
        output out_valid, out_last, texture_idx, y_idx, x_idx, busy
    );
endinterface

// File: rtl/mode7_coord_gen.sv
// Mode 7 affine texel-address generator: per scanline, steps (u,v) by a
// signed per-pixel delta and emits H_PIXELS texture ROM addresses via valid/ready.
module mode7_coord_gen #(
    parameter int H_PIXELS  = 160,
    parameter int INT_BITS  = 12,
    parameter int FRAC_BITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    mode7_coord_gen_if.slave bus
);
    localparam int         ACC_W    = INT_BITS + FRAC_BITS;
    localparam logic [11:0] LAST_PIX = 12'(H_PIXELS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [ACC_W-1:0] u_acc, u_n;
    logic [ACC_W-1:0] v_acc, v_n;
    logic [ACC_W-1:0] du_q, du_n;
    logic [ACC_W-1:0] dv_q, dv_n;
    logic [11:0]      cnt, cnt_n;
    logic             last_q, last_n;

    always_comb begin
        state_n = state;
        u_n     = u_acc;
        v_n     = v_acc;
        du_n    = du_q;
        dv_n    = dv_q;
        cnt_n   = cnt;
        // line_start has priority, including over the last-pixel handshake
        if (bus.line_start) begin
            u_n     = bus.line_u0;
            v_n     = bus.line_v0;
            du_n    = {{(ACC_W-16){bus.du_dx[15]}}, bus.du_dx};
            dv_n    = {{(ACC_W-16){bus.dv_dx[15]}}, bus.dv_dx};
            cnt_n   = '0;
            state_n = RUN;
        end else if (state == RUN && bus.out_ready) begin
            if (cnt == LAST_PIX) begin
                state_n = IDLE;
            end else begin
                u_n   = u_acc + du_q;
                v_n   = v_acc + dv_q;
                cnt_n = cnt + 12'd1;
            end
        end
        last_n = (state_n == RUN) && (cnt_n == LAST_PIX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            u_acc  <= '0;
            v_acc  <= '0;
            du_q   <= '0;
            dv_q   <= '0;
            cnt    <= '0;
            last_q <= 1'b0;
        end else begin
            state  <= state_n;
            u_acc  <= u_n;
            v_acc  <= v_n;
            du_q   <= du_n;
            dv_q   <= dv_n;
            cnt    <= cnt_n;
            last_q <= last_n;
        end
    end

    assign bus.out_valid   = (state == RUN);
    assign bus.busy        = (state == RUN);
    assign bus.out_last    = last_q;
    assign bus.x_idx       = u_acc[FRAC_BITS+4:FRAC_BITS];
    assign bus.y_idx       = v_acc[FRAC_BITS+4:FRAC_BITS];
    assign bus.texture_idx = {v_acc[FRAC_BITS+6:FRAC_BITS+5], u_acc[FRAC_BITS+6:FRAC_BITS+5]};
endmodule
